div_arbiter: RTL

- Round-robin arbiter and sequencer that shares one multi-cycle signed divider among NUM_REQ requesters, e.g. the demod phase-normaliser, AGC gain calculator and de-emphasis coefficient update.
- Accepts one request at a time and holds its operands stable on the divider for the whole operation.
- Waits for the divider's done pulse, then returns the quotient and flags to the granted requester over a valid/ready response channel.
- Sits between the requesters and the divider; the divider is instantiated alongside it.

---
 rtl/div_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter that shares one multi-cycle signed divider.
// Holds the granted operands and returns quotient, overflow and timeout flags.
module div_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DIVIDEND_WIDTH = 64,
  parameter int DIVISOR_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]   req_dividend,
  input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]    req_divisor,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  input  logic [NUM_REQ-1:0]                  rsp_ready,
  output logic [DIVIDEND_WIDTH-1:0]           rsp_quotient,
  output logic                                rsp_overflow,
  output logic                                rsp_timeout,
  output logic                                div_valid_in,
  output logic [DIVIDEND_WIDTH-1:0]           div_dividend,
  output logic [DIVISOR_WIDTH-1:0]            div_divisor,
  output logic                                div_abort,
  input  logic [DIVIDEND_WIDTH-1:0]           div_quotient,
  input  logic                                div_valid_out
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [PW-1:0]             r_ptr;
  logic [PW-1:0]             r_owner;
  logic [DIVIDEND_WIDTH-1:0] r_dvd;
  logic [DIVISOR_WIDTH-1:0]  r_dvs;
  logic [DIVIDEND_WIDTH-1:0] r_quot;
  logic                      r_ovf;
  logic                      r_tmo;
  logic [CW-1:0]             r_cnt;

  logic [DIVIDEND_WIDTH-1:0] w_dvd [NUM_REQ];
  logic [DIVISOR_WIDTH-1:0]  w_dvs [NUM_REQ];
  logic [PW-1:0]             w_idx;
  logic [PW-1:0]             w_gnt;
  logic                      w_gnt_ok;
  logic [NUM_REQ-1:0]        w_gnt_oh;
  logic [NUM_REQ-1:0]        w_own_oh;
  logic                      w_accept;
  logic                      w_done;
  logic                      w_tmo_hit;
  logic                      w_rsp_on;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_dvd[i] =
      req_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
    assign w_dvs[i] =
      req_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
  end

  // Nearest set bit after r_ptr wins: scan far-to-near, last hit sticks.
  always_comb begin
    w_gnt_ok = 1'b0;
    w_gnt    = '0;
    w_idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_idx = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (req_valid[w_idx]) begin
        w_gnt_ok = 1'b1;
        w_gnt    = w_idx;
      end
    end
  end

  assign w_gnt_oh = NUM_REQ'(1) << w_gnt;
  assign w_own_oh = NUM_REQ'(1) << r_owner;

  always_comb begin
    w_next       = r_state;
    req_ready    = '0;
    rsp_valid    = '0;
    div_valid_in = 1'b0;
    div_abort    = 1'b0;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_tmo_hit    = 1'b0;
    if (!reset) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_ok) begin
            req_ready = w_gnt_oh;
            w_accept  = 1'b1;
            w_next    = S_ISSUE;
          end
        end
        S_ISSUE: begin
          div_valid_in = 1'b1;
          w_next       = S_WAIT;
        end
        S_WAIT: begin
          if (div_valid_out) begin
            w_done = 1'b1;
            w_next = S_RESP;
          end else if (r_cnt == CW'(TIMEOUT_CYCLES)) begin
            div_abort = 1'b1;
            w_tmo_hit = 1'b1;
            w_next    = S_RESP;
          end
        end
        S_RESP: begin
          rsp_valid = w_own_oh;
          if (rsp_ready[r_owner]) begin
            w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= PW'(NUM_REQ - 1);
      r_owner <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_quot  <= '0;
      r_ovf   <= 1'b0;
      r_tmo   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_owner <= w_gnt;
        r_ptr   <= w_gnt;
        r_dvd   <= w_dvd[w_gnt];
        r_dvs   <= w_dvs[w_gnt];
        r_ovf   <= (w_dvs[w_gnt] == '0);
        r_tmo   <= 1'b0;
      end
      if (r_state == S_ISSUE) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_done) begin
        r_quot <= div_quotient;
        r_tmo  <= 1'b0;
      end
      if (w_tmo_hit) begin
        r_quot <= '0;
        r_tmo  <= 1'b1;
      end
    end
  end

  assign w_rsp_on     = (r_state == S_RESP) && !reset;
  assign rsp_quotient = w_rsp_on ? r_quot : '0;
  assign rsp_overflow = w_rsp_on & r_ovf;
  assign rsp_timeout  = w_rsp_on & r_tmo;
  assign div_dividend = r_dvd;
  assign div_divisor  = r_dvs;

endmodule
